ysyx_22050039_idu_pipe: RTL and testbench

Pipelined, parametrised instruction-decode stage for the single-issue RV64I core. It sits between the fetch stage and the execute stage and owns the general-purpose register file, full RV64I immediate generation and a register scoreboard that stalls on RAW/WAW hazards. It decouples fetch and execute through a one-entry output register with valid/ready handshakes on both sides, and accepts write-backs from a dedicated port.

---
 rtl/ysyx_22050039_pkg.sv | 31 +++
 rtl/ysyx_22050039_regfile.sv | 52 +++++
 rtl/ysyx_22050039_idu_pipe.sv | 235 +++++++++++++++++++++++
 tb/tb_ysyx_22050039_idu_pipe.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050039_pkg.sv
// Shared decode constants for the ysyx_22050039 IDU: opcodes,
// the ebreak encoding and the bit positions of the one-hot out_type.
package ysyx_22050039_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [31:0] EBREAK = 32'h00100073;

  localparam int TYPE_R = 5;
  localparam int TYPE_I = 4;
  localparam int TYPE_S = 3;
  localparam int TYPE_B = 2;
  localparam int TYPE_U = 1;
  localparam int TYPE_J = 0;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } obuf_state_e;

endpackage

// File: rtl/ysyx_22050039_regfile.sv
// GPR file: NR_REG x XLEN, two async read ports, one write port, x0 = 0.
// Ports: clk, rst (async active-low), ra1/ra2 -> rd1/rd2, we/wa/wd.
// Macro IDU_WB_BYPASS_EN forwards the same-cycle write to the reads.
module ysyx_22050039_regfile #(
  parameter int XLEN    = 64,
  parameter int NR_REG  = 32,
  parameter int REG_SEL = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REG_SEL-1:0] ra1,
  input  logic [REG_SEL-1:0] ra2,
  output logic [XLEN-1:0]    rd1,
  output logic [XLEN-1:0]    rd2,
  input  logic               we,
  input  logic [REG_SEL-1:0] wa,
  input  logic [XLEN-1:0]    wd
);

  logic [XLEN-1:0] rf_q [NR_REG];
  logic [XLEN-1:0] rf_d [NR_REG];

  always_comb begin
    rf_d = rf_q;
    if (we && wa != '0) rf_d[wa] = wd;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NR_REG; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

`ifdef IDU_WB_BYPASS_EN
  always_comb begin
    rd1 = rf_q[ra1];
    rd2 = rf_q[ra2];
    if (we && wa == ra1) rd1 = wd;
    if (we && wa == ra2) rd2 = wd;
    if (ra1 == '0) rd1 = '0;
    if (ra2 == '0) rd2 = '0;
  end
`else
  always_comb begin
    rd1 = (ra1 == '0) ? '0 : rf_q[ra1];
    rd2 = (ra2 == '0) ? '0 : rf_q[ra2];
  end
`endif

endmodule

// File: rtl/ysyx_22050039_idu_pipe.sv
// RV64I decode stage: decode, imm gen, RAW/WAW scoreboard, 1-entry out reg.
// Ports: in_* fetch hs, out_* execute hs, wb_* write-back, flush, rst (async low).
// Macro IDU_WB_BYPASS_EN lets a same-cycle write-back resolve a hazard.
module ysyx_22050039_idu_pipe
  import ysyx_22050039_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int INST_LEN = 32,
  parameter int NR_REG   = 32,
  parameter int REG_SEL  = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INST_LEN-1:0] in_inst,
  input  logic [XLEN-1:0]     in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_pc,
  output logic [XLEN-1:0]     out_src1,
  output logic [XLEN-1:0]     out_src2,
  output logic [XLEN-1:0]     out_imm,
  output logic [REG_SEL-1:0]  out_rd,
  output logic                out_rd_wen,
  output logic [5:0]          out_type,
  output logic [6:0]          out_opcode,
  output logic [2:0]          out_funct3,
  output logic [6:0]          out_funct7,
  output logic                out_ebreak,
  output logic                out_illegal,
  input  logic                wb_valid,
  input  logic [REG_SEL-1:0]  wb_rd,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                flush
);

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    src1;
    logic [XLEN-1:0]    src2;
    logic [XLEN-1:0]    imm;
    logic [REG_SEL-1:0] rd;
    logic               rd_wen;
    logic [5:0]         typ;
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic               ebreak;
    logic               illegal;
  } id_ex_t;

  logic [6:0]         opc;
  logic [REG_SEL-1:0] rs1, rs2, rd;
  logic               s;
  logic [XLEN-1:0]    rdata1, rdata2;

  assign opc = in_inst[6:0];
  assign rd  = in_inst[11:7];
  assign rs1 = in_inst[19:15];
  assign rs2 = in_inst[24:20];
  assign s   = in_inst[31];

  logic is_r, is_i, is_s, is_b, is_u, is_j, is_ebk;
  assign is_r   = (opc == OP_OP) || (opc == OP_OP32);
  assign is_i   = (opc == OP_LOAD) || (opc == OP_IMM) ||
                  (opc == OP_IMM32) || (opc == OP_JALR);
  assign is_s   = (opc == OP_STORE);
  assign is_b   = (opc == OP_BRANCH);
  assign is_u   = (opc == OP_LUI) || (opc == OP_AUIPC);
  assign is_j   = (opc == OP_JAL);
  assign is_ebk = (in_inst[31:0] == EBREAK);

  logic [5:0]      typ;
  logic [XLEN-1:0] imm;
  logic            use1, use2, wr, ebk, ill, rd_wen;

  always_comb begin
    typ  = '0;
    imm  = '0;
    use1 = 1'b0;
    use2 = 1'b0;
    wr   = 1'b0;
    ebk  = 1'b0;
    ill  = 1'b0;
    unique case (1'b1)
      is_r: begin
        typ[TYPE_R] = 1'b1;
        use1 = 1'b1;
        use2 = 1'b1;
        wr   = 1'b1;
      end
      is_i: begin
        typ[TYPE_I] = 1'b1;
        imm  = {{(XLEN-12){s}}, in_inst[31:20]};
        use1 = 1'b1;
        wr   = 1'b1;
      end
      is_s: begin
        typ[TYPE_S] = 1'b1;
        imm  = {{(XLEN-12){s}}, in_inst[31:25], in_inst[11:7]};
        use1 = 1'b1;
        use2 = 1'b1;
      end
      is_b: begin
        typ[TYPE_B] = 1'b1;
        imm  = {{(XLEN-13){s}}, s, in_inst[7],
                in_inst[30:25], in_inst[11:8], 1'b0};
        use1 = 1'b1;
        use2 = 1'b1;
      end
      is_u: begin
        typ[TYPE_U] = 1'b1;
        imm = {{(XLEN-32){s}}, in_inst[31:12], 12'b0};
        wr  = 1'b1;
      end
      is_j: begin
        typ[TYPE_J] = 1'b1;
        imm = {{(XLEN-21){s}}, s, in_inst[19:12],
               in_inst[20], in_inst[30:21], 1'b0};
        wr  = 1'b1;
      end
      is_ebk: ebk = 1'b1;
      default: ill = 1'b1;
    endcase
  end

  assign rd_wen = wr && (rd != '0);

  obuf_state_e        state_q, state_d;
  logic [NR_REG-1:0]  busy_q, busy_d, busy_chk;
  id_ex_t             out_q, out_d;
  logic               hazard, in_hs, out_hs, full;

  assign full = (state_q == ST_FULL);

  // Busy view used for the hazard check; a bypassed write-back
  // already counts as retired in its own cycle.
  always_comb begin
    busy_chk = busy_q;
`ifdef IDU_WB_BYPASS_EN
    if (wb_valid) busy_chk[wb_rd] = 1'b0;
`endif
    busy_chk[0] = 1'b0;
  end

  assign hazard = in_valid && ((use1 && busy_chk[rs1]) ||
                               (use2 && busy_chk[rs2]) ||
                               (rd_wen && busy_chk[rd]));

  assign in_ready = rst && !flush && !hazard && (!full || out_ready);
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = full && out_ready;

  // Set after clears so a new claim wins over a same-rd release.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid) busy_d[wb_rd] = 1'b0;
    if (flush && full && out_q.rd_wen) busy_d[out_q.rd] = 1'b0;
    if (in_hs && rd_wen) busy_d[rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: if (in_hs) state_d = ST_FULL;
      ST_FULL: begin
        if (flush) state_d = ST_EMPTY;
        else if (in_hs) state_d = ST_FULL;
        else if (out_hs) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    out_d = out_q;
    if (in_hs) begin
      out_d.pc      = in_pc;
      out_d.src1    = rdata1;
      out_d.src2    = rdata2;
      out_d.imm     = imm;
      out_d.rd      = rd;
      out_d.rd_wen  = rd_wen;
      out_d.typ     = typ;
      out_d.opcode  = opc;
      out_d.funct3  = in_inst[14:12];
      out_d.funct7  = in_inst[31:25];
      out_d.ebreak  = ebk;
      out_d.illegal = ill;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      busy_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      out_q   <= out_d;
    end
  end

  ysyx_22050039_regfile #(
    .XLEN(XLEN), .NR_REG(NR_REG), .REG_SEL(REG_SEL)
  ) u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (rs1),
    .ra2 (rs2),
    .rd1 (rdata1),
    .rd2 (rdata2),
    .we  (wb_valid),
    .wa  (wb_rd),
    .wd  (wb_data)
  );

  assign out_valid   = full;
  assign out_pc      = out_q.pc;
  assign out_src1    = out_q.src1;
  assign out_src2    = out_q.src2;
  assign out_imm     = out_q.imm;
  assign out_rd      = out_q.rd;
  assign out_rd_wen  = out_q.rd_wen;
  assign out_type    = out_q.typ;
  assign out_opcode  = out_q.opcode;
  assign out_funct3  = out_q.funct3;
  assign out_funct7  = out_q.funct7;
  assign out_ebreak  = out_q.ebreak;
  assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_ysyx_22050039_idu_pipe.sv
// Self-checking bench for ysyx_22050039_idu_pipe: decode table,
// hazard/flush/reset sequences, and random traffic against a model.
module tb_ysyx_22050039_idu_pipe;

`ifdef IDU_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;
  logic        out_valid, out_ready;
  logic [63:0] out_pc, out_src1, out_src2, out_imm;
  logic [4:0]  out_rd;
  logic        out_rd_wen;
  logic [5:0]  out_type;
  logic [6:0]  out_opcode, out_funct7;
  logic [2:0]  out_funct3;
  logic        out_ebreak, out_illegal;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        flush;

  always #5 clk = ~clk;

  ysyx_22050039_idu_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_src1(out_src1), .out_src2(out_src2),
    .out_imm(out_imm), .out_rd(out_rd), .out_rd_wen(out_rd_wen),
    .out_type(out_type), .out_opcode(out_opcode),
    .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_ebreak(out_ebreak), .out_illegal(out_illegal),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush)
  );

  typedef struct packed {
    logic [63:0] pc, src1, src2, imm;
    logic [4:0]  rd;
    logic        rd_wen;
    logic [5:0]  typ;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        ebk, ill;
  } oreg_t;

  typedef struct packed {
    oreg_t o;
    bit    u1, u2;
  } dec_t;

  typedef struct {
    logic [31:0] inst;
    logic [5:0]  typ;
    logic [63:0] imm;
    logic [4:0]  rd;
    logic        wen, ebk, ill;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_gpr [32];
  bit   [31:0] m_busy;
  bit          m_full;
  oreg_t       m_out;
  bit          last_acc;

  task automatic chk(string name, logic [319:0] act, logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic oreg_t dut_o();
    return {out_pc, out_src1, out_src2, out_imm, out_rd, out_rd_wen,
            out_type, out_opcode, out_funct3, out_funct7,
            out_ebreak, out_illegal};
  endfunction

  // Reference decode: immediates built from weighted fields, sign by
  // subtracting the weight of the top bit.
  function automatic dec_t ref_decode(logic [31:0] i, logic [63:0] pc);
    dec_t   d;
    longint v;
    bit     wr;
    d = '0;
    v = 0;
    wr = 0;
    d.o.pc = pc;
    d.o.opc = i[6:0];
    d.o.f3 = i[14:12];
    d.o.f7 = i[31:25];
    d.o.rd = i[11:7];
    case (i[6:0])
      7'h33, 7'h3B: begin
        d.o.typ = 6'b100000; d.u1 = 1; d.u2 = 1; wr = 1;
      end
      7'h03, 7'h13, 7'h1B, 7'h67: begin
        d.o.typ = 6'b010000; d.u1 = 1; wr = 1;
        v = longint'(i[31:20]);
        if (i[31]) v -= 4096;
      end
      7'h23: begin
        d.o.typ = 6'b001000; d.u1 = 1; d.u2 = 1;
        v = longint'(i[31:25]) * 32 + longint'(i[11:7]);
        if (i[31]) v -= 4096;
      end
      7'h63: begin
        d.o.typ = 6'b000100; d.u1 = 1; d.u2 = 1;
        v = longint'(i[7]) * 2048 + longint'(i[30:25]) * 32
          + longint'(i[11:8]) * 2;
        if (i[31]) v -= 4096;
      end
      7'h37, 7'h17: begin
        d.o.typ = 6'b000010; wr = 1;
        v = longint'(i[31:12]) * 4096;
        if (i[31]) v -= (longint'(1) << 32);
      end
      7'h6F: begin
        d.o.typ = 6'b000001; wr = 1;
        v = longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048
          + longint'(i[30:21]) * 2;
        if (i[31]) v -= (longint'(1) << 20);
      end
      default: begin
        if (i == 32'h00100073) d.o.ebk = 1;
        else d.o.ill = 1;
      end
    endcase
    d.o.imm = v;
    d.o.rd_wen = wr && (i[11:7] != 0);
    return d;
  endfunction

  function automatic logic [63:0] srcval(logic [4:0] r);
    if (r == 0) return 64'd0;
    if (BYP && wb_valid && wb_rd == r) return wb_data;
    return m_gpr[r];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 32; k++) m_gpr[k] = '0;
    m_busy = '0;
    m_full = 0;
    m_out = '0;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_inst = '0; in_pc = '0; out_ready = 0;
    wb_valid = 0; wb_rd = '0; wb_data = '0; flush = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1;
  endtask

  // One cycle: called just after a negedge with inputs applied.
  task automatic step();
    dec_t        d;
    bit   [31:0] eb;
    bit          haz, rdy, inhs;
    logic [63:0] s1, s2;
    #1;
    d = ref_decode(in_inst, in_pc);
    eb = m_busy;
    if (BYP && wb_valid) eb[wb_rd] = 0;
    eb[0] = 0;
    haz = in_valid && ((d.u1 && eb[in_inst[19:15]]) ||
                       (d.u2 && eb[in_inst[24:20]]) ||
                       (d.o.rd_wen && eb[in_inst[11:7]]));
    rdy = !flush && !haz && (!m_full || out_ready);
    chk("in_ready", {319'd0, in_ready}, {319'd0, rdy});
    inhs = in_valid && rdy;
    s1 = srcval(in_inst[19:15]);
    s2 = srcval(in_inst[24:20]);
    @(posedge clk);
    if (wb_valid) m_busy[wb_rd] = 0;
    if (flush && m_full && m_out.rd_wen) m_busy[m_out.rd] = 0;
    if (inhs && d.o.rd_wen) m_busy[d.o.rd] = 1;
    m_busy[0] = 0;
    if (wb_valid && wb_rd != 0) m_gpr[wb_rd] = wb_data;
    if (flush) m_full = 0;
    else if (inhs) m_full = 1;
    else if (out_ready) m_full = 0;
    if (inhs) begin
      m_out = d.o;
      m_out.src1 = s1;
      m_out.src2 = s2;
    end
    last_acc = inhs;
    @(negedge clk);
    chk("out_valid", {319'd0, out_valid}, {319'd0, m_full});
    chk("out_fields", {32'd0, dut_o()}, {32'd0, m_out});
  endtask

  vec_t vt [11];
  int   issue_cyc;

  initial begin
    vt[0]  = '{32'hFFF00093, 6'b010000, 64'hFFFFFFFFFFFFFFFF, 5'd1, 1, 0, 0};
    vt[1]  = '{32'hFFDFF06F, 6'b000001, 64'hFFFFFFFFFFFFFFFC, 5'd0, 0, 0, 0};
    vt[2]  = '{32'h00100073, 6'b000000, 64'h0, 5'd0, 0, 1, 0};
    vt[3]  = '{32'hFFFFFFFF, 6'b000000, 64'h0, 5'd31, 0, 0, 1};
    vt[4]  = '{32'h123452B7, 6'b000010, 64'h12345000, 5'd5, 1, 0, 0};
    vt[5]  = '{32'hFE20AC23, 6'b001000, 64'hFFFFFFFFFFFFFFF8, 5'd24, 0, 0, 0};
    vt[6]  = '{32'hFE0008E3, 6'b000100, 64'hFFFFFFFFFFFFFFF0, 5'd17, 0, 0, 0};
    vt[7]  = '{32'h002081B3, 6'b100000, 64'h0, 5'd3, 1, 0, 0};
    vt[8]  = '{32'h001000EF, 6'b000001, 64'h800, 5'd1, 1, 0, 0};
    vt[9]  = '{32'h80000017, 6'b000010, 64'hFFFFFFFF80000000, 5'd0, 0, 0, 0};
    vt[10] = '{32'h7FF3839B, 6'b010000, 64'h7FF, 5'd7, 1, 0, 0};

    // Reset state
    rst = 0;
    idle_inputs();
    model_reset();
    #1;
    chk("rst_in_ready", {319'd0, in_ready}, 320'd0);
    chk("rst_out_valid", {319'd0, out_valid}, 320'd0);
    chk("rst_fields", {32'd0, dut_o()}, 320'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1;

    // Decode table
    foreach (vt[n]) begin
      do_reset();
      in_valid = 1;
      in_inst = vt[n].inst;
      in_pc = 64'h8000_0000 + 64'(n) * 4;
      out_ready = 1;
      step();
      in_valid = 0;
      chk($sformatf("vec%0d", n),
          {239'd0, out_valid, out_type, out_imm, out_rd,
           out_rd_wen, out_ebreak, out_illegal},
          {239'd0, 1'b1, vt[n].typ, vt[n].imm, vt[n].rd,
           vt[n].wen, vt[n].ebk, vt[n].ill});
    end

    // RAW stall released by write-back of x1 three cycles later
    do_reset();
    out_ready = 1;
    in_valid = 1;
    in_inst = 32'h00100093;
    step();
    issue_cyc = -1;
    for (int c = 1; c < 10; c++) begin
      in_inst = 32'h00108133;
      wb_valid = (c == 3);
      wb_rd = 5'd1;
      wb_data = 64'd5;
      step();
      if (last_acc) begin
        issue_cyc = c;
        break;
      end
    end
    in_valid = 0;
    wb_valid = 0;
    chk("raw_issue_cycle", 320'(issue_cyc), BYP ? 320'd3 : 320'd4);
    chk("raw_src1", {256'd0, out_src1}, 320'd5);
    chk("raw_src2", {256'd0, out_src2}, 320'd5);

    // Backpressure hold, then flush clears the killed rd's busy bit
    do_reset();
    out_ready = 1;
    in_valid = 1;
    in_inst = 32'hFFF00093;
    step();
    out_ready = 0;
    in_inst = 32'h123452B7;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("hold_no_accept", {319'd0, last_acc}, 320'd0);
    end
    chk("hold_imm", {256'd0, out_imm}, {256'd0, 64'hFFFFFFFFFFFFFFFF});
    chk("hold_rd", {315'd0, out_rd}, 320'd1);
    flush = 1;
    step();
    flush = 0;
    in_valid = 0;
    chk("flush_valid", {319'd0, out_valid}, 320'd0);
    in_valid = 1;
    in_inst = 32'h00108133;
    out_ready = 1;
    #1;
    chk("flush_busy_clr", {319'd0, in_ready}, 320'd1);
    step();
    in_valid = 0;

    // Mid-stream reset with x1 written and busy
    do_reset();
    out_ready = 1;
    wb_valid = 1;
    wb_rd = 5'd1;
    wb_data = 64'h55;
    step();
    wb_valid = 0;
    in_valid = 1;
    in_inst = 32'hFFF00093;
    step();
    in_valid = 0;
    out_ready = 0;
    step();
    #2;
    rst = 0;
    #1;
    chk("arst_out_valid", {319'd0, out_valid}, 320'd0);
    chk("arst_in_ready", {319'd0, in_ready}, 320'd0);
    chk("arst_fields", {32'd0, dut_o()}, 320'd0);
    model_reset();
    @(negedge clk);
    rst = 1;
    in_valid = 1;
    in_inst = 32'h00108133;
    out_ready = 1;
    step();
    in_valid = 0;
    chk("arst_accept", {319'd0, last_acc}, 320'd1);
    chk("arst_x1_zero", {256'd0, out_src1}, 320'd0);

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [6:0] ops [11];
      logic [31:0] ins;
      ops = '{7'h03, 7'h13, 7'h1B, 7'h17, 7'h23, 7'h33,
              7'h3B, 7'h37, 7'h63, 7'h67, 7'h6F};
      ins = $urandom;
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 0) ins = 32'h00100073;
      end else begin
        ins[6:0] = ops[$urandom_range(0, 10)];
        ins[11:7] = 5'($urandom_range(0, 7));
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
      end
      in_inst = ins;
      in_valid = ($urandom_range(0, 3) != 0);
      in_pc = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 19) == 0);
      wb_valid = ($urandom_range(0, 9) < 3);
      wb_rd = 5'($urandom_range(0, 7));
      if (m_busy != 0 && $urandom_range(0, 4) != 0) begin
        for (int t = 0; t < 32; t++) begin
          wb_rd = 5'($urandom_range(1, 7));
          if (m_busy[wb_rd]) break;
        end
      end
      wb_data = {$urandom, $urandom};
      step();
    end
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
